// File: rtl/dmem_rsp_pkg.sv
// dmem_rsp_pkg: shared types and constants for the data-memory responder.
//   state_e    - responder FSM states (IDLE, WAIT, RESP)
//   CNT_W      - width of the wait-state counter
//   NUM_LANES  - byte lanes per 32-bit word
package dmem_rsp_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int CNT_W     = 4;
   localparam int NUM_LANES = 4;
endpackage

// File: rtl/dmem_rsp_ram.sv
// dmem_rsp_ram: DEPTH_WORDS x 32 storage with per-byte write enables and a
// registered read port.
//   i_clk, i_rst_n - clock, async active-low reset (read register only)
//   i_en           - perform an access this edge
//   i_we / i_be    - write lanes enabled in i_be (only when i_we)
//   i_zero         - load 0 into the read register instead of array data
//   i_idx          - word index
//   i_wdata        - write data
//   o_rdata        - registered read data, updated only on i_en
import dmem_rsp_pkg::*;

module dmem_rsp_ram #(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic                 i_we,
   input  logic                 i_zero,
   input  logic [IDX_W-1:0]     i_idx,
   input  logic [31:0]          i_wdata,
   input  logic [NUM_LANES-1:0] i_be,
   output logic [31:0]          o_rdata
);
   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   // Array itself is never reset.
   always_ff @(posedge i_clk) begin
      if (i_en && i_we) begin
         for (int b = 0; b < NUM_LANES; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_en) r_rdata <= i_zero ? 32'h0 : r_mem[i_idx];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with configurable
// wait states, honouring the core's single-step clock enable.
//   i_clk, i_rst_n, i_clk_en           - clock, async active-low reset, enable
//   i_req_valid/o_req_ready            - request handshake
//   i_req_we/addr/wdata/be             - request payload
//   o_rsp_valid/i_rsp_ready            - response handshake
//   o_rsp_rdata, o_rsp_err             - response payload
// Optional: define DMEM_RSP_BOUNDS_CHECK_EN to flag addresses whose bits above
// the word index are nonzero (store suppressed, rdata 0, o_rsp_err 1).
import dmem_rsp_pkg::*;

module dmem_responder #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clk_en,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic                 i_req_we,
   input  logic [ADDR_W-1:0]    i_req_addr,
   input  logic [31:0]          i_req_wdata,
   input  logic [NUM_LANES-1:0] i_req_be,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [31:0]          o_rsp_rdata,
   output logic                 o_rsp_err
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e               r_state, w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_we, r_oob;
   logic [IDX_W-1:0]     r_idx;
   logic [31:0]          r_wdata;
   logic [NUM_LANES-1:0] r_be;

   logic                 w_accept, w_mem_en, w_addr_oob, w_unused_addr;
   logic                 w_acc_we, w_acc_oob;
   logic [IDX_W-1:0]     w_acc_idx;
   logic [31:0]          w_acc_wdata;
   logic [NUM_LANES-1:0] w_acc_be;

   assign w_accept   = (r_state == IDLE) && i_req_valid && i_clk_en;
   assign w_addr_oob = |i_req_addr[ADDR_W-1:IDX_W+2];

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = (WAIT_STATES == 0) ? RESP : WAIT;
         // Counter is loaded with WAIT_STATES and counts down to 0; the
         // RESP transition happens one enabled edge after it reaches 0.
         WAIT:    if (i_clk_en && r_cnt == '0) w_next = RESP;
         RESP:    if (i_clk_en && i_rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_oob   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else if (w_accept) begin
         r_cnt   <= CNT_W'(WAIT_STATES);
         r_we    <= i_req_we;
         r_oob   <= w_addr_oob;
         r_idx   <= i_req_addr[IDX_W+1:2];
         r_wdata <= i_req_wdata;
         r_be    <= i_req_be;
      end else if (r_state == WAIT && i_clk_en && r_cnt != '0) begin
         r_cnt   <= r_cnt - 1'b1;
      end
   end

   // With zero wait states the access happens on the accept edge itself, so
   // the payload comes straight from the request inputs while in IDLE.
   always_comb begin
      w_acc_we    = r_we;
      w_acc_idx   = r_idx;
      w_acc_wdata = r_wdata;
      w_acc_be    = r_be;
      w_acc_oob   = r_oob;
      if (r_state == IDLE) begin
         w_acc_we    = i_req_we;
         w_acc_idx   = i_req_addr[IDX_W+1:2];
         w_acc_wdata = i_req_wdata;
         w_acc_be    = i_req_be;
         w_acc_oob   = w_addr_oob;
      end
   end

   // Access on the edge entering RESP; gated by reset so an accept seen while
   // reset is asserted cannot touch the unreset array.
   assign w_mem_en = (w_next == RESP) && (r_state != RESP) && i_rst_n;

`ifdef DMEM_RSP_BOUNDS_CHECK_EN
   logic r_err;
   logic w_oob_eff;
   assign w_oob_eff = w_acc_oob;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      r_err <= 1'b0;
      else if (w_mem_en) r_err <= w_acc_oob;
   end

   assign o_rsp_err     = r_err;
   assign w_unused_addr = ^i_req_addr[1:0];
`else
   logic w_oob_eff;
   assign w_oob_eff     = 1'b0;
   assign o_rsp_err     = 1'b0;
   assign w_unused_addr = ^{i_req_addr[1:0], w_acc_oob};
`endif

   dmem_rsp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_mem_en),
      .i_we    (w_acc_we && !w_oob_eff),
      .i_zero  (w_acc_we || w_oob_eff),
      .i_idx   (w_acc_idx),
      .i_wdata (w_acc_wdata),
      .i_be    (w_acc_be),
      .o_rdata (o_rsp_rdata)
   );

   assign o_req_ready = (r_state == IDLE);
   assign o_rsp_valid = (r_state == RESP);
endmodule
